// File: rtl/exu_cal_mc.sv
// Multi-cycle ALU between execute issue and writeback: single-cycle arithmetic/logic/compare,
// iterative shifts of SHIFT_STEP bits per cycle, registered result behind a valid/ready handshake.
module exu_cal_mc #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hs_ex4cal_val,
  output logic            hs_cal4ex_rdy,
  input  logic [9:0]      i_op,
  input  logic [XLEN-1:0] i_opn1,
  input  logic [XLEN-1:0] i_opn2,
  output logic            hs_cal4wb_val,
  input  logic            hs_wb4cal_rdy,
  output logic [XLEN-1:0] res
);

  localparam int unsigned SW   = $clog2(XLEN);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_e;

  state_e          state_q, state_d;
  shkind_e         kind_q, kind_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [SW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic [XLEN:0]   sub_s, sub_u;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] ld_res;
  logic            ld_is_sh;
  shkind_e         ld_kind;
  logic [SW:0]     k;
  logic [XLEN-1:0] sh_res;

  assign hs_cal4ex_rdy = (state_q == IDLE) | ((state_q == DONE) & hs_wb4cal_rdy);
  assign hs_cal4wb_val = (state_q == DONE);
  assign res           = res_q;
  assign accept        = hs_ex4cal_val & hs_cal4ex_rdy;
  assign shamt         = i_opn2[SW-1:0];

  // Result of a freshly accepted request; shifts only preload the operand here.
  always_comb begin
    sub_s    = {i_opn1[XLEN-1], i_opn1} - {i_opn2[XLEN-1], i_opn2};
    sub_u    = {1'b0, i_opn1} - {1'b0, i_opn2};
    ld_res   = '0;
    ld_is_sh = 1'b0;
    ld_kind  = SH_LL;
    if ($onehot(i_op)) begin
      case (1'b1)
        i_op[0]: ld_res = i_opn1 + i_opn2;
        i_op[1]: ld_res = i_opn1 - i_opn2;
        i_op[2]: begin ld_res = i_opn1; ld_is_sh = 1'b1; ld_kind = SH_LL; end
        i_op[3]: begin ld_res = i_opn1; ld_is_sh = 1'b1; ld_kind = SH_RL; end
        i_op[4]: begin ld_res = i_opn1; ld_is_sh = 1'b1; ld_kind = SH_RA; end
        i_op[5]: ld_res = i_opn1 ^ i_opn2;
        i_op[6]: ld_res = i_opn1 | i_opn2;
        i_op[7]: ld_res = i_opn1 & i_opn2;
        i_op[8]: ld_res = {{(XLEN-1){1'b0}}, sub_s[XLEN]};
        i_op[9]: ld_res = {{(XLEN-1){1'b0}}, sub_u[XLEN]};
        default: ld_res = '0;
      endcase
    end
  end

  // One iterative shift step of min(SHIFT_STEP, remaining) bits.
  always_comb begin
    k = ({1'b0, cnt_q} < STEP) ? {1'b0, cnt_q} : STEP;
    case (kind_q)
      SH_LL:   sh_res = res_q << k;
      SH_RL:   sh_res = res_q >> k;
      SH_RA:   sh_res = $signed(res_q) >>> k;
      default: sh_res = res_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    case (state_q)
      IDLE, DONE: begin
        // A DONE handshake with a simultaneous accept loads the new op with no bubble.
        if (accept) begin
          res_d  = ld_res;
          kind_d = ld_kind;
          if (ld_is_sh) cnt_d = shamt;
          state_d = (ld_is_sh && (shamt != '0)) ? SHIFT : DONE;
        end else if (state_q == DONE && hs_wb4cal_rdy) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = sh_res;
        cnt_d = cnt_q - k[SW-1:0];
        if (cnt_q == k[SW-1:0]) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= SH_LL;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_exu_cal_mc.sv
// Scoreboard bench for exu_cal_mc: driver pushes model results, negedge monitor checks value and latency.
module tb_exu_cal_mc;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STEP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hs_ex4cal_val = 1'b0;
  logic            hs_cal4ex_rdy;
  logic [9:0]      i_op = '0;
  logic [XLEN-1:0] i_opn1 = '0;
  logic [XLEN-1:0] i_opn2 = '0;
  logic            hs_cal4wb_val;
  logic            hs_wb4cal_rdy = 1'b1;
  logic [XLEN-1:0] res;

  exu_cal_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .hs_ex4cal_val(hs_ex4cal_val), .hs_cal4ex_rdy(hs_cal4ex_rdy),
    .i_op(i_op), .i_opn1(i_opn1), .i_opn2(i_opn2),
    .hs_cal4wb_val(hs_cal4wb_val), .hs_wb4cal_rdy(hs_wb4cal_rdy),
    .res(res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    int              first;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wb_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit   fresh = 1'b1;

  localparam logic [9:0] ADD = 10'd1, SUB = 10'd2, SLL = 10'd4, SRL = 10'd8, SRA = 10'd16,
                         XOR = 10'd32, OR = 10'd64, AND = 10'd128, SLT = 10'd256, SLTU = 10'd512;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [9:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                output logic [XLEN-1:0] r, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = '0;
    lat = 1;
    if ($countones(op) == 1) begin
      if (op == ADD)  r = a + b;
      if (op == SUB)  r = a - b;
      if (op == XOR)  r = a ^ b;
      if (op == OR)   r = a | b;
      if (op == AND)  r = a & b;
      if (op == SLT)  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (op == SLTU) r = (a < b) ? 32'd1 : 32'd0;
      if (op == SLL)  r = a << sh;
      if (op == SRL)  r = a >> sh;
      if (op == SRA)  r = $signed(a) >>> sh;
      if (op == SLL || op == SRL || op == SRA) lat = (sh + STEP - 1) / STEP + 1;
    end
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic rst, input logic v, input logic [9:0] op,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(posedge clk);
    #1;
    rst_n = rst;
    hs_ex4cal_val = v;
    i_op = op;
    i_opn1 = a;
    i_opn2 = b;
    hs_wb4cal_rdy = (wb_mode == 0) ? 1'b1 : (wb_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic issue(input logic [9:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int   n;
    bit   done;
    exp_t e;
    int   lat;
    n = 0;
    done = 1'b0;
    while (!done) begin
      drive(1'b1, 1'b1, op, a, b);
      if (hs_cal4ex_rdy === 1'b1) begin
        model(op, a, b, e.res, lat);
        e.first = cyc + lat;
        q.push_back(e);
        done = 1'b1;
      end else if (++n > 64) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: rdy stuck at %b expected 1", hs_cal4ex_rdy);
        done = 1'b1;
      end
    end
  endtask

  // Monitor: compares the presented result and its first-valid cycle against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      fresh = 1'b1;
    end else if (hs_cal4wb_val === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: res %h with empty scoreboard (cycle %0d)", res, cyc);
      end else begin
        if (fresh) begin
          total++;
          if (cyc != q[0].first) begin
            bad++;
            $display("FAIL latency: valid at cycle %0d expected cycle %0d", cyc, q[0].first);
          end
          fresh = 1'b0;
        end
        chk("result", res, q[0].res);
        if (hs_wb4cal_rdy) begin
          void'(q.pop_front());
          fresh = 1'b1;
        end else begin
          chk("rdy_during_stall", {31'b0, hs_cal4ex_rdy}, 32'd0);
        end
      end
    end else if (q.size() > 0 && cyc > q[0].first) begin
      total++;
      bad++;
      $display("FAIL missing_valid: nothing by cycle %0d expected at %0d res %h", cyc, q[0].first, q[0].res);
      void'(q.pop_front());
      fresh = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [9:0]  op;
    logic [XLEN-1:0] a, b;

    // Reset held with a request pending
    drive(1'b0, 1'b1, ADD, 32'h1, 32'h2);
    drive(1'b0, 1'b1, ADD, 32'h1, 32'h2);
    drive(1'b1, 1'b0, '0, '0, '0);
    chk("reset_res", res, 32'h0);
    chk("reset_val", {31'b0, hs_cal4wb_val}, 32'd0);
    chk("reset_rdy", {31'b0, hs_cal4ex_rdy}, 32'd1);

    // Back-to-back single-cycle ops
    issue(ADD, 32'hFFFF_FFFF, 32'h1);
    issue(SUB, 32'd5, 32'd7);
    issue(SLT, 32'h8000_0000, 32'h1);
    issue(SLTU, 32'h8000_0000, 32'h1);
    idle(3);

    // Full-length shifts and short shifts
    issue(SRA, 32'h8000_0000, 32'd31);
    issue(SRL, 32'h8000_0000, 32'd31);
    issue(SLL, 32'h1, 32'd31);
    issue(SLL, 32'h1234_5678, 32'd0);
    issue(SRL, 32'hF000_0000, 32'd4);
    issue(SLL, 32'h0000_000F, 32'd4);
    issue(SRA, 32'h8765_4321, 32'd5);
    idle(12);

    // Writeback stall, then release with a new request in the same cycle
    wb_mode = 2;
    issue(XOR, 32'hA5A5_0000, 32'h00FF_FF00);
    idle(5);
    chk("stall_rdy", {31'b0, hs_cal4ex_rdy}, 32'd0);
    wb_mode = 0;
    issue(OR, 32'h0F00_0000, 32'h0000_00F0);
    idle(3);

    // Reset in the third SHIFT cycle of SRL by 20
    issue(SRL, 32'hDEAD_BEEF, 32'd20);
    drive(1'b1, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    chk("midshift_reset_val", {31'b0, hs_cal4wb_val}, 32'd0);
    chk("midshift_reset_rdy", {31'b0, hs_cal4ex_rdy}, 32'd1);
    idle(8);

    // Illegal op encodings
    issue(10'b00_0000_0011, 32'h1111_1111, 32'h2222_2222);
    issue(10'b00_0000_0000, 32'h3333_3333, 32'h4444_4444);
    idle(3);

    // Randomised traffic with random writeback backpressure
    wb_mode = 1;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 19);
      if (n < 18) op = 10'(1 << $urandom_range(0, 9));
      else op = 10'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {1'b1, a[30:0]};
      issue(op, a, b);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    // Drain
    wb_mode = 0;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      idle(1);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
